// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/de/address generator with address lookahead and pixel scaling.
// Define VGA_TIMING_FRAME_COUNT_EN to add the frame_count output.
module vga_timing_gen #(
    parameter int PIXEL_WIDTH   = 640,
    parameter int PIXEL_HEIGHT  = 480,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit H_SYNC_POL    = 1'b0,
    parameter bit V_SYNC_POL    = 1'b0,
    parameter int ADDR_LEAD     = 2,
    parameter int SCALE_SHIFT   = 0
) (
    input  logic                                          pxclk,
    input  logic                                          rst_n,
    input  logic                                          en,
    output logic                                          hsync,
    output logic                                          vsync,
    output logic                                          de,
    output logic [$clog2(PIXEL_WIDTH >> SCALE_SHIFT)-1:0] xaddr,
    output logic [$clog2(PIXEL_HEIGHT >> SCALE_SHIFT)-1:0] yaddr,
    output logic                                          addr_valid,
    output logic                                          line_start,
    output logic                                          frame_start,
    output logic                                          vblank
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]                                   frame_count
`endif
);
    localparam int H_TOTAL = PIXEL_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = PIXEL_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int XW = $clog2(PIXEL_WIDTH >> SCALE_SHIFT);
    localparam int YW = $clog2(PIXEL_HEIGHT >> SCALE_SHIFT);
    localparam logic [HW-1:0] H_ACT   = HW'(PIXEL_WIDTH);
    localparam logic [HW-1:0] H_SYNC0 = HW'(PIXEL_WIDTH + H_FRONT_PORCH);
    localparam logic [HW-1:0] H_SYNC1 = HW'(PIXEL_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(PIXEL_HEIGHT);
    localparam logic [VW-1:0] V_SYNC0 = VW'(PIXEL_HEIGHT + V_FRONT_PORCH);
    localparam logic [VW-1:0] V_SYNC1 = VW'(PIXEL_HEIGHT + V_FRONT_PORCH + V_SYNC_PULSE);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [2:0]    SYNC_IDLE = {~H_SYNC_POL, ~V_SYNC_POL, 1'b0};

    if (H_FRONT_PORCH < 1 || H_SYNC_PULSE < 1 || H_BACK_PORCH < 1 ||
        V_FRONT_PORCH < 1 || V_SYNC_PULSE < 1 || V_BACK_PORCH < 1) begin : g_bad_porch
        $fatal(1, "vga_timing_gen: porch and sync widths must be >= 1");
    end
    if (ADDR_LEAD < 0 || ADDR_LEAD > 7 || SCALE_SHIFT < 0 || SCALE_SHIFT > 2) begin : g_bad_range
        $fatal(1, "vga_timing_gen: ADDR_LEAD must be 0..7 and SCALE_SHIFT 0..2");
    end
    if ((PIXEL_WIDTH % (1 << SCALE_SHIFT)) != 0 || (PIXEL_HEIGHT % (1 << SCALE_SHIFT)) != 0) begin : g_bad_scale
        $fatal(1, "vga_timing_gen: active size must be divisible by the scale factor");
    end

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          act_d, ls_d, fs_d, vb_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [2:0]    sync_d;
    logic          act_q, ls_q, fs_q, vb_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [2:0]    sync_q [ADDR_LEAD+1];

    always_comb begin
        h_d    = (h_q == H_LAST) ? '0 : h_q + 1'b1;
        v_d    = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
        act_d  = (h_q < H_ACT) && (v_q < V_ACT);
        x_d    = act_d ? XW'(h_q >> SCALE_SHIFT) : '0;
        y_d    = act_d ? YW'(v_q >> SCALE_SHIFT) : '0;
        ls_d   = h_q == '0;
        fs_d   = ls_d && (v_q == '0);
        vb_d   = v_q >= V_ACT;
        sync_d = {(h_q >= H_SYNC0 && h_q < H_SYNC1) ? H_SYNC_POL : ~H_SYNC_POL,
                  (v_q >= V_SYNC0 && v_q < V_SYNC1) ? V_SYNC_POL : ~V_SYNC_POL,
                  act_d};
    end

    // sync_q[0] shares the address-stage register; the rest form the lookahead delay
    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            act_q  <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            vb_q   <= 1'b0;
            for (int i = 0; i <= ADDR_LEAD; i++) sync_q[i] <= SYNC_IDLE;
        end else if (en) begin
            h_q       <= h_d;
            v_q       <= v_d;
            act_q     <= act_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ls_q      <= ls_d;
            fs_q      <= fs_d;
            vb_q      <= vb_d;
            sync_q[0] <= sync_d;
            for (int i = 1; i <= ADDR_LEAD; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {hsync, vsync, de} = sync_q[ADDR_LEAD];
    assign addr_valid  = act_q;
    assign xaddr       = x_q;
    assign yaddr       = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign vblank      = vb_q;

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic        seen_q;
    logic [15:0] fc_q;

    // the first frame after reset reports 0; later frames count up
    always_ff @(posedge pxclk or negedge rst_n) begin
        if (!rst_n) begin
            seen_q <= 1'b0;
            fc_q   <= '0;
        end else if (en && fs_d) begin
            seen_q <= 1'b1;
            if (seen_q) fc_q <= fc_q + 16'd1;
        end
    end

    assign frame_count = fc_q;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen in a default mode and two small modes.
module tb_vga_timing_gen;
    typedef struct packed {
        logic       av;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic       vb;
    } addr_t;
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    localparam int MW  [3] = '{640, 8, 8};
    localparam int MH  [3] = '{480, 4, 4};
    localparam int MHF [3] = '{16, 2, 2};
    localparam int MHS [3] = '{96, 3, 3};
    localparam int MHB [3] = '{48, 1, 1};
    localparam int MVF [3] = '{10, 1, 1};
    localparam int MVS [3] = '{2, 2, 2};
    localparam int MVB [3] = '{33, 1, 1};
    localparam int MSS [3] = '{0, 1, 1};
    localparam int MLD [3] = '{2, 5, 0};
    localparam int MHP [3] = '{0, 1, 1};
    localparam int MVP [3] = '{0, 0, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    int   tests = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    logic       hs0, vs0, de0, av0, ls0, fs0, vb0;
    logic [9:0] x0;
    logic [8:0] y0;
    logic       hs1, vs1, de1, av1, ls1, fs1, vb1;
    logic [1:0] x1;
    logic [0:0] y1;
    logic       hs2, vs2, de2, av2, ls2, fs2, vb2;
    logic [1:0] x2;
    logic [0:0] y2;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc0, fc1, fc2;
`endif

    vga_timing_gen d0 (
`ifdef VGA_TIMING_FRAME_COUNT_EN
        .frame_count(fc0),
`endif
        .pxclk(clk), .rst_n(rst_n), .en(en), .hsync(hs0), .vsync(vs0), .de(de0),
        .xaddr(x0), .yaddr(y0), .addr_valid(av0), .line_start(ls0),
        .frame_start(fs0), .vblank(vb0)
    );

    vga_timing_gen #(
        .PIXEL_WIDTH(MW[1]), .PIXEL_HEIGHT(MH[1]), .H_FRONT_PORCH(MHF[1]),
        .H_SYNC_PULSE(MHS[1]), .H_BACK_PORCH(MHB[1]), .V_FRONT_PORCH(MVF[1]),
        .V_SYNC_PULSE(MVS[1]), .V_BACK_PORCH(MVB[1]), .H_SYNC_POL(1'b1),
        .V_SYNC_POL(1'b0), .ADDR_LEAD(MLD[1]), .SCALE_SHIFT(MSS[1])
    ) d1 (
`ifdef VGA_TIMING_FRAME_COUNT_EN
        .frame_count(fc1),
`endif
        .pxclk(clk), .rst_n(rst_n), .en(en), .hsync(hs1), .vsync(vs1), .de(de1),
        .xaddr(x1), .yaddr(y1), .addr_valid(av1), .line_start(ls1),
        .frame_start(fs1), .vblank(vb1)
    );

    vga_timing_gen #(
        .PIXEL_WIDTH(MW[2]), .PIXEL_HEIGHT(MH[2]), .H_FRONT_PORCH(MHF[2]),
        .H_SYNC_PULSE(MHS[2]), .H_BACK_PORCH(MHB[2]), .V_FRONT_PORCH(MVF[2]),
        .V_SYNC_PULSE(MVS[2]), .V_BACK_PORCH(MVB[2]), .H_SYNC_POL(1'b1),
        .V_SYNC_POL(1'b0), .ADDR_LEAD(MLD[2]), .SCALE_SHIFT(MSS[2])
    ) d2 (
`ifdef VGA_TIMING_FRAME_COUNT_EN
        .frame_count(fc2),
`endif
        .pxclk(clk), .rst_n(rst_n), .en(en), .hsync(hs2), .vsync(vs2), .de(de2),
        .xaddr(x2), .yaddr(y2), .addr_valid(av2), .line_start(ls2),
        .frame_start(fs2), .vblank(vb2)
    );

    addr_t oa [3];
    sync_t os [3];
    assign oa[0] = {av0, x0, 1'b0, y0, ls0, fs0, vb0};
    assign oa[1] = {av1, 8'd0, x1, 9'd0, y1, ls1, fs1, vb1};
    assign oa[2] = {av2, 8'd0, x2, 9'd0, y2, ls2, fs2, vb2};
    assign os[0] = {hs0, vs0, de0};
    assign os[1] = {hs1, vs1, de1};
    assign os[2] = {hs2, vs2, de2};

    int    mh [3];
    int    mv [3];
    addr_t aq [3][$];
    sync_t sq [3][$];
    addr_t la [3];
    sync_t lsy [3];

    function automatic int ht(int k);
        return MW[k] + MHF[k] + MHS[k] + MHB[k];
    endfunction

    function automatic int vt(int k);
        return MH[k] + MVF[k] + MVS[k] + MVB[k];
    endfunction

    function automatic sync_t idle(int k);
        return {~1'(MHP[k]), ~1'(MVP[k]), 1'b0};
    endfunction

    function automatic addr_t m_addr(int k, int h, int v);
        addr_t a;
        logic  act;
        act  = (h < MW[k]) && (v < MH[k]);
        a.av = act;
        a.x  = act ? 10'(h >> MSS[k]) : 10'd0;
        a.y  = act ? 10'(v >> MSS[k]) : 10'd0;
        a.ls = (h == 0);
        a.fs = (h == 0) && (v == 0);
        a.vb = (v >= MH[k]);
        return a;
    endfunction

    function automatic sync_t m_sync(int k, int h, int v);
        sync_t s;
        int    h0, v0;
        h0   = MW[k] + MHF[k];
        v0   = MH[k] + MVF[k];
        s.hs = (h >= h0 && h < h0 + MHS[k]) ? 1'(MHP[k]) : ~1'(MHP[k]);
        s.vs = (v >= v0 && v < v0 + MVS[k]) ? 1'(MVP[k]) : ~1'(MVP[k]);
        s.de = (h < MW[k]) && (v < MH[k]);
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            aq[k].delete();
            sq[k].delete();
            mh[k]  = 0;
            mv[k]  = 0;
            la[k]  = '0;
            lsy[k] = idle(k);
            repeat (MLD[k]) sq[k].push_back(idle(k));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick(input bit e);
        @(negedge clk);
        en = e;
        if (e) begin
            for (int k = 0; k < 3; k++) begin
                aq[k].push_back(m_addr(k, mh[k], mv[k]));
                sq[k].push_back(m_sync(k, mh[k], mv[k]));
                if (mh[k] == ht(k) - 1) begin
                    mh[k] = 0;
                    mv[k] = (mv[k] == vt(k) - 1) ? 0 : mv[k] + 1;
                end else begin
                    mh[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
        if (e) begin
            for (int k = 0; k < 3; k++) begin
                la[k]  = aq[k].pop_front();
                lsy[k] = sq[k].pop_front();
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (oa[k] !== '0) begin
                failed++;
                $display("FAIL reset_addr dut%0d got=%h exp=%h", k, oa[k], 24'h0);
            end
            tests++;
            if (os[k] !== idle(k)) begin
                failed++;
                $display("FAIL reset_sync dut%0d got=%b exp=%b", k, os[k], idle(k));
            end
        end
        model_reset();
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL first_addr dut%0d n=%0d got=%h exp=%h", k, n, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL first_sync dut%0d n=%0d got=%b exp=%b", k, n, os[k], lsy[k]);
                end
            end
            if (n == 1) begin
                tests++;
                if ({av0, ls0, fs0, x0, y0} !== {3'b111, 19'd0}) begin
                    failed++;
                    $display("FAIL first_pos got=%b exp=%b", {av0, ls0, fs0, x0, y0}, {3'b111, 19'd0});
                end
                tests++;
                if (de2 !== 1'b1) begin
                    failed++;
                    $display("FAIL de_lead0 got=%b exp=1", de2);
                end
            end
            if (n == 5 || n == 6) begin
                tests++;
                if (de1 !== (n == 6)) begin
                    failed++;
                    $display("FAIL de_lead5 n=%0d got=%b exp=%b", n, de1, n == 6);
                end
            end
        end
    endtask

    task automatic test_line_timing();
        int   ls_t [$];
        int   hf = -1;
        int   hr = -1;
        int   avcnt = 0;
        logic prev_hs = 1'b1;
        do_reset();
        for (int c = 0; c < 1700; c++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL line_addr dut%0d c=%0d got=%h exp=%h", k, c, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL line_sync dut%0d c=%0d got=%b exp=%b", k, c, os[k], lsy[k]);
                end
            end
            if (ls0) ls_t.push_back(c);
            if (prev_hs && !hs0 && hf < 0) hf = c;
            if (!prev_hs && hs0 && hf >= 0 && hr < 0) hr = c;
            prev_hs = hs0;
            if (c < 800 && av0) avcnt++;
        end
        tests++;
        if (ls_t.size() != 3) begin
            failed++;
            $display("FAIL line_count got=%0d exp=3", ls_t.size());
        end else begin
            tests++;
            if (ls_t[1] - ls_t[0] != 800 || ls_t[2] - ls_t[1] != 800) begin
                failed++;
                $display("FAIL line_period got=%0d,%0d exp=800", ls_t[1] - ls_t[0], ls_t[2] - ls_t[1]);
            end
            tests++;
            if (hf - ls_t[0] != 658) begin
                failed++;
                $display("FAIL hsync_start got=%0d exp=658", hf - ls_t[0]);
            end
        end
        tests++;
        if (avcnt != 640) begin
            failed++;
            $display("FAIL active_count got=%0d exp=640", avcnt);
        end
        tests++;
        if (hr - hf != 96) begin
            failed++;
            $display("FAIL hsync_width got=%0d exp=96", hr - hf);
        end
    endtask

    task automatic test_frame();
        int vcnt = 0;
        int vbcnt = 0;
        int vfirst = -1;
        int maxx = 0;
        int maxy = 0;
        int fs_t [$];
        do_reset();
        for (int c = 0; c < 224; c++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL frame_addr dut%0d c=%0d got=%h exp=%h", k, c, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL frame_sync dut%0d c=%0d got=%b exp=%b", k, c, os[k], lsy[k]);
                end
            end
            if (c < 112 && !vs2) vcnt++;
            if (c < 112 && vb2) vbcnt++;
            if (!vs2 && vfirst < 0) vfirst = c;
            if (int'(x1) > maxx) maxx = int'(x1);
            if (int'(y1) > maxy) maxy = int'(y1);
            if (fs2) fs_t.push_back(c);
        end
        tests++;
        if (vcnt != 28 || vfirst != 70) begin
            failed++;
            $display("FAIL vsync_window got=%0d@%0d exp=28@70", vcnt, vfirst);
        end
        tests++;
        if (vbcnt != 56) begin
            failed++;
            $display("FAIL vblank_count got=%0d exp=56", vbcnt);
        end
        tests++;
        if (maxx != 3 || maxy != 1) begin
            failed++;
            $display("FAIL scale_range got=%0d,%0d exp=3,1", maxx, maxy);
        end
        tests++;
        if (fs_t.size() != 2 || fs_t[0] != 0 || fs_t[1] != 112) begin
            failed++;
            $display("FAIL frame_period got=%0d pulses exp=2 at 0,112", fs_t.size());
        end
    endtask

    task automatic test_lead();
        int hs_t [3] = '{-1, -1, -1};
        int de_t [3] = '{-1, -1, -1};
        do_reset();
        for (int c = 0; c < 40; c++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL lead_addr dut%0d c=%0d got=%h exp=%h", k, c, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL lead_sync dut%0d c=%0d got=%b exp=%b", k, c, os[k], lsy[k]);
                end
            end
            if (hs1 && hs_t[1] < 0) hs_t[1] = c;
            if (hs2 && hs_t[2] < 0) hs_t[2] = c;
            if (de1 && de_t[1] < 0) de_t[1] = c;
            if (de2 && de_t[2] < 0) de_t[2] = c;
        end
        tests++;
        if (hs_t[1] != 15 || hs_t[2] != 10) begin
            failed++;
            $display("FAIL hsync_lead got=%0d,%0d exp=15,10", hs_t[1], hs_t[2]);
        end
        tests++;
        if (de_t[1] != 5 || de_t[2] != 0) begin
            failed++;
            $display("FAIL de_lead got=%0d,%0d exp=5,0", de_t[1], de_t[2]);
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 3) != 0);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL en_addr dut%0d c=%0d en=%b got=%h exp=%h", k, c, en, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL en_sync dut%0d c=%0d en=%b got=%b exp=%b", k, c, en, os[k], lsy[k]);
                end
            end
        end
        do_reset();
        repeat (300) tick(1'b1);
        tests++;
        if (x0 !== 10'd299 || av0 !== 1'b1) begin
            failed++;
            $display("FAIL midline_pos got=%0d exp=299", x0);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (oa[k] !== '0) begin
                failed++;
                $display("FAIL async_addr dut%0d got=%h exp=%h", k, oa[k], 24'h0);
            end
            tests++;
            if (os[k] !== idle(k)) begin
                failed++;
                $display("FAIL async_sync dut%0d got=%b exp=%b", k, os[k], idle(k));
            end
        end
        en = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1'b1);
            for (int k = 0; k < 3; k++) begin
                tests++;
                if (oa[k] !== la[k]) begin
                    failed++;
                    $display("FAIL restart_addr dut%0d c=%0d got=%h exp=%h", k, c, oa[k], la[k]);
                end
                tests++;
                if (os[k] !== lsy[k]) begin
                    failed++;
                    $display("FAIL restart_sync dut%0d c=%0d got=%b exp=%b", k, c, os[k], lsy[k]);
                end
            end
        end
    endtask

`ifdef VGA_TIMING_FRAME_COUNT_EN
    task automatic test_frame_count();
        logic [15:0] fexp = 16'd0;
        bit          first = 1'b1;
        do_reset();
        for (int c = 0; c < 620; c++) begin
            if (c == 396) begin
                @(negedge clk);
                force d2.fc_q = 16'hFFFF;
                #1;
                release d2.fc_q;
                fexp = 16'hFFFF;
            end
            tick(1'b1);
            if (fs2) begin
                if (!first) fexp = fexp + 16'd1;
                first = 1'b0;
                tests++;
                if (fc2 !== fexp) begin
                    failed++;
                    $display("FAIL frame_count c=%0d got=%h exp=%h", c, fc2, fexp);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line_timing();
        test_frame();
        test_lead();
        test_enable_reset();
`ifdef VGA_TIMING_FRAME_COUNT_EN
        test_frame_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
